add_serial_sched: RTL and testbench
===================================

Name: add_serial_sched

Overview:
- Round-robin scheduler that shares one 8-bit bit-serial adder (one result bit per cycle) among NREQ requesters.
- Accepts operand pairs over a valid/ready handshake and drives the adder's start/operand interface.
- Counts the adder's fixed latency, captures the sum, and returns it tagged with the requester ID.
- Sits between client FSMs and the single serial adder instance in the datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/sum width; must match the adder.
- ADD_LAT, 10, cycles from the adder start cycle to a stable adder sum (1 enable-sample + 1 prime + WIDTH shifts); must be ≥2.
- IDW, 2, requester-ID width; must satisfy 2**IDW ≥ NREQ.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  NREQ  per-requester operand-pair valid.
- req_a  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a.
- req_ready  out  NREQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_sum  out  WIDTH  sum modulo 2**WIDTH.
- add_en  out  1  adder start strobe, active-high, one cycle.
- add_a  out  WIDTH  operand A to the adder; held stable for the whole job.
- add_b  out  WIDTH  operand B to the adder; held stable for the whole job.
- add_out  in  WIDTH  adder result register.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; rr_ptr=0; cnt=0. All outputs are 0: req_ready, rsp_valid, rsp_id, rsp_sum, add_en, add_a, add_b. Reset mid-job abandons the job with no response; the adder is assumed reset alongside.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, any req_valid set:
  - Winner = first set bit searching upward from rr_ptr, wrapping at NREQ.
  - Latch the winner's req_a/req_b into add_a/add_b and the winner index into id_q.
  - Pulse req_ready[winner] in this same cycle (combinational from state==IDLE and the winner).
  - Set rr_ptr = (winner+1) mod NREQ; go to ISSUE.
- IDLE, no req_valid: stay in IDLE; all strobes stay 0.
- ISSUE: add_en=1 for exactly this cycle; cnt=0; go to WAIT.
- WAIT: cnt increments each cycle. When cnt==ADD_LAT-1, capture add_out into rsp_sum and go to RESP.
- RESP:
  - rsp_valid=1 for one cycle; rsp_id=id_q.
  - rsp_sum holds its value until the next capture.
  - Go to IDLE.
- Request handshake: a requester must hold req_valid and its operands stable until it sees req_ready. Dropping req_valid before the grant is legal and withdraws the request.
- Throughput: at most one job in flight. Job period = ADD_LAT+3 cycles (IDLE, ISSUE, WAIT×ADD_LAT, RESP).
- Response latency: first rsp_valid comes ADD_LAT+2 cycles after the req_ready cycle.
- Simultaneous requests: exactly one grant per job; losers keep waiting.
- A requester may re-request in the RESP cycle. It is arbitrated on the next IDLE with the updated rr_ptr.
- Fairness: no starvation with all requesters permanently valid; every requester is served within NREQ jobs.
- Arithmetic: no carry-out; overflow wraps (e.g. 0xFF+0x01 → 0x00).
- rr_ptr wrap: NREQ-1 → 0.
- Out-of-range requester IDs (≥NREQ) never win.

Optional Feature:
- Macro: ADD_SERIAL_SCHED_PRIO_EN.
- Defined: requester 0 is high priority. If req_valid[0]=1 in IDLE, it wins regardless of rr_ptr, and rr_ptr is left unchanged. All other requesters use round-robin as described.
- Undefined: pure round-robin for all requesters; requester 0 gets no special treatment.

Decomposition:
- Shared package add_serial_pkg holds:
  - state enum: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3;
  - the WIDTH default;
  - the ADD_LAT default.
- Sub-module rr_arb (parameter NREQ): combinational round-robin winner select.
  - Inputs: req, ptr.
  - Outputs: any, winner index, one-hot grant.
  - Instantiated once.

Test Plan:
- Single request: req_valid=0001, A=0x35, B=0x4A → req_ready=0001 for 1 cycle; add_en 1 cycle later; rsp_valid with rsp_id=0, rsp_sum=0x7F exactly ADD_LAT+2 cycles after req_ready.
- Overflow: requester 2 sends A=0xFF, B=0x01 → rsp_id=2, rsp_sum=0x00.
- All four requesters held valid from reset, with A=i, B=0x10 → grants in order 0,1,2,3,0; sums 0x10,0x11,0x12,0x13; jobs spaced ADD_LAT+3 cycles apart.
- Withdrawal: requester 1 raises then drops req_valid while requester 3's job is in WAIT → no grant to 1; next IDLE with no request stays idle, no strobes.
- Reset in WAIT: drive rst=0 for 1 cycle → next cycle all outputs 0, no rsp_valid. A fresh request after reset is served from rr_ptr=0.
- PRIO_EN build: requesters 0 and 2 both held valid → requester 0 wins every job; with the macro undefined, requesters 0 and 2 alternate.

Source files
------------

// File: rtl/add_serial_sched_pkg.sv
// Shared types and defaults for the serial-adder scheduler.
package add_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int unsigned WIDTH_DEF   = 8;
  localparam int unsigned ADD_LAT_DEF = 10;

  // Index width that stays at least one bit for tiny ranges
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_serial_sched_if.sv
// Request/response and adder-side signals of the serial-adder scheduler.
interface add_serial_sched_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = add_serial_pkg::WIDTH_DEF,
  parameter int unsigned IDW   = 2
) ();

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  add_en;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic [WIDTH-1:0]      add_out;

  modport master (
    output req_valid, req_a, req_b, add_out,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, add_en, add_a, add_b
  );

  modport slave (
    input  req_valid, req_a, req_b, add_out,
    output req_ready, rsp_valid, rsp_id, rsp_sum, add_en, add_a, add_b
  );

endinterface

// File: rtl/add_serial_sched_rr_arb.sv
// Combinational round-robin select: first set request at or above ptr, wrapping.
module rr_arb
  import add_serial_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [idx_w(NREQ)-1:0]  ptr,
  output logic                    any,
  output logic [idx_w(NREQ)-1:0]  winner,
  output logic [NREQ-1:0]         grant
);

  localparam int unsigned PW = idx_w(NREQ);

  int unsigned idx;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!any && req[PW'(idx)]) begin
        any    = 1'b1;
        winner = PW'(idx);
      end
    end
    grant = any ? (NREQ'(1) << winner) : '0;
  end

endmodule

// File: rtl/add_serial_sched.sv
// Shares one bit-serial adder among NREQ requesters, one job in flight at a time.
// Build option ADD_SERIAL_SCHED_PRIO_EN: requester 0 preempts round-robin and leaves rr_ptr untouched.
module add_serial_sched
  import add_serial_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned ADD_LAT = ADD_LAT_DEF,
  parameter int unsigned IDW     = 2
) (
  input logic               clk,
  input logic               rst,
  add_serial_sched_if.slave bus
);

  localparam int unsigned PW = idx_w(NREQ);
  localparam int unsigned CW = idx_w(ADD_LAT);

  state_t           state;
  logic [PW-1:0]    rr_ptr;
  logic [CW-1:0]    cnt;
  logic [IDW-1:0]   id_q;

  logic             arb_any;
  logic [PW-1:0]    arb_idx;
  logic [NREQ-1:0]  arb_gnt;
  logic [PW-1:0]    sel_idx;
  logic [NREQ-1:0]  sel_gnt;
  logic             keep_ptr;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  rr_arb #(.NREQ(NREQ)) u_arb (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .any    (arb_any),
    .winner (arb_idx),
    .grant  (arb_gnt)
  );

  // Final winner, with optional fixed priority for requester 0
  always_comb begin
    sel_idx  = arb_idx;
    sel_gnt  = arb_gnt;
    keep_ptr = 1'b0;
`ifdef ADD_SERIAL_SCHED_PRIO_EN
    if (bus.req_valid[0]) begin
      sel_idx  = '0;
      sel_gnt  = NREQ'(1);
      keep_ptr = 1'b1;
    end
`else
`endif
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (PW'(k) == sel_idx) begin
        sel_a = bus.req_a[k*WIDTH +: WIDTH];
        sel_b = bus.req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  // Accept pulse is same-cycle so the requester can drop valid right after
  assign bus.req_ready = (rst && (state == IDLE) && arb_any) ? sel_gnt : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cnt           <= '0;
      id_q          <= '0;
      bus.add_en    <= 1'b0;
      bus.add_a     <= '0;
      bus.add_b     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_sum   <= '0;
    end else begin
      bus.add_en    <= 1'b0;
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            bus.add_a  <= sel_a;
            bus.add_b  <= sel_b;
            id_q       <= IDW'(sel_idx);
            if (!keep_ptr) begin
              rr_ptr <= (sel_idx == PW'(NREQ-1)) ? '0 : sel_idx + PW'(1);
            end
            bus.add_en <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == CW'(ADD_LAT-1)) begin
            bus.rsp_sum   <= bus.add_out;
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= id_q;
            state         <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_serial_sched.sv
// Scoreboard bench for add_serial_sched with a latency-accurate adder model.
module tb_add_serial_sched;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int ADD_LAT = 10;
  localparam int IDW     = 2;

  typedef struct {
    int         id;
    logic [7:0] sum;
    int         gcyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  add_serial_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  add_serial_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .ADD_LAT(ADD_LAT), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Adder model: result is only correct ADD_LAT cycles after the start strobe
  int         acnt = 0;
  logic [7:0] asum = '0;
  always @(posedge clk) begin
    if (!rst) begin
      acnt <= 0;
      asum <= '0;
    end else if (bus.add_en) begin
      acnt <= 1;
      asum <= bus.add_a + bus.add_b;
    end else if (acnt > 0 && acnt < ADD_LAT) begin
      acnt <= acnt + 1;
    end
  end
  assign bus.add_out = (acnt >= ADD_LAT) ? asum : ~asum;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int model_win(input logic [NREQ-1:0] v, input int p);
`ifdef ADD_SERIAL_SCHED_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
    return -1;
  endfunction

  int         cyc = 0;
  logic       rst_q = 1'b0;
  int         m_ptr = 0;
  int         idle_from = 0;
  int         en_at = -1;
  int         n_rsp = 0;
  int         last_id = -1;
  logic [7:0] last_sum = '0;
  logic [7:0] ea, eb;
  int         glog[$];
  exp_t       sb[$];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  always @(negedge clk) begin : mon
    int w;
    logic [7:0] a_i, b_i;
    exp_t e;
    if (!rst_q) begin
      check_eq("reset_out", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.add_en, bus.add_a, bus.add_b}), 0);
      m_ptr = 0;
      sb.delete();
      idle_from = cyc;
      en_at = -1;
    end
    if (!rst) begin
      if (bus.req_ready != '0) check_eq("ready_in_reset", 32'(bus.req_ready), 0);
    end else if (cyc >= idle_from && bus.req_valid != '0) begin
      w = model_win(bus.req_valid, m_ptr);
      check_eq("grant", 32'(bus.req_ready), 32'(1 << w));
      glog.push_back(onehot_idx(bus.req_ready));
      a_i = bus.req_a[w*WIDTH +: WIDTH];
      b_i = bus.req_b[w*WIDTH +: WIDTH];
      sb.push_back('{id: w, sum: 8'(a_i + b_i), gcyc: cyc});
`ifdef ADD_SERIAL_SCHED_PRIO_EN
      if (!bus.req_valid[0]) m_ptr = (w + 1) % NREQ;
`else
      m_ptr = (w + 1) % NREQ;
`endif
      idle_from = cyc + ADD_LAT + 3;
      en_at = cyc + 1;
      ea = a_i;
      eb = b_i;
    end else if (bus.req_ready != '0) begin
      check_eq("ready_unexp", 32'(bus.req_ready), 0);
    end
    if (cyc == en_at) begin
      check_eq("add_en", 32'(bus.add_en), 1);
      check_eq("add_ops", 32'({bus.add_a, bus.add_b}), 32'({ea, eb}));
    end else if (bus.add_en) begin
      check_eq("add_en_unexp", 32'(bus.add_en), 0);
    end
    if (bus.rsp_valid) begin
      n_rsp++;
      last_id  = int'(bus.rsp_id);
      last_sum = bus.rsp_sum;
      if (sb.size() == 0) begin
        check_eq("rsp_unexp", 32'(bus.rsp_valid), 0);
      end else begin
        e = sb.pop_front();
        check_eq("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        check_eq("rsp_sum", 32'(bus.rsp_sum), 32'(e.sum));
        check_eq("rsp_latency", 32'(cyc - e.gcyc), 32'(ADD_LAT + 2));
      end
    end
  end

  // Helpers leave the caller 1 time unit after a posedge, ready to drive
  task automatic wait_grants(input int n);
    for (int t = 0; t < 400; t++) begin
      @(posedge clk);
      if (glog.size() >= n) begin
        #1;
        return;
      end
    end
    check_eq("grant_timeout", 32'(glog.size()), 32'(n));
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      if (sb.size() == 0 && cyc >= idle_from) begin
        #1;
        return;
      end
    end
    check_eq("drain_timeout", 32'(sb.size()), 0);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic request(input int i, input logic [7:0] a, input logic [7:0] b);
    int base;
    base = glog.size();
    set_req(i, a, b);
    wait_grants(base + 1);
    bus.req_valid[i] = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int base;
    int nr;
    int fair_exp[5];
    int alt_exp[4];
`ifdef ADD_SERIAL_SCHED_PRIO_EN
    fair_exp = '{0, 0, 0, 0, 0};
    alt_exp  = '{0, 0, 0, 0};
`else
    fair_exp = '{0, 1, 2, 3, 0};
    alt_exp  = '{2, 0, 2, 0};
`endif
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    request(0, 8'h35, 8'h4A);
    drain();
    check_eq("single_id", 32'(last_id), 0);
    check_eq("single_sum", 32'(last_sum), 32'h7F);

    request(2, 8'hFF, 8'h01);
    drain();
    check_eq("ovf_id", 32'(last_id), 2);
    check_eq("ovf_sum", 32'(last_sum), 32'h00);

    // All requesters valid straight out of reset
    base = glog.size();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(i), 8'h10);
    @(posedge clk);
    #1 rst = 1'b1;
    wait_grants(base + 5);
    bus.req_valid = '0;
    drain();
    for (int k = 0; k < 5; k++) check_eq("fair_order", 32'(glog[base+k]), 32'(fair_exp[k]));

    // Requester 1 withdraws while requester 3 is being served
    base = glog.size();
    request(3, 8'h20, 8'h07);
    repeat (4) @(posedge clk);
    #1 set_req(1, 8'h55, 8'h11);
    repeat (3) @(posedge clk);
    #1 bus.req_valid[1] = 1'b0;
    drain();
    repeat (6) @(posedge clk);
    #1;
    check_eq("withdraw_grants", 32'(glog.size()), 32'(base + 1));
    check_eq("withdraw_id", 32'(glog[base]), 3);

    // Reset while a job is waiting on the adder
    request(1, 8'h22, 8'h33);
    repeat (5) @(posedge clk);
    nr = n_rsp;
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (ADD_LAT + 5) @(posedge clk);
    #1;
    check_eq("abandon_rsp", 32'(n_rsp), 32'(nr));
    base = glog.size();
    set_req(1, 8'h0A, 8'h0B);
    set_req(3, 8'h30, 8'h03);
    wait_grants(base + 1);
    bus.req_valid = '0;
    drain();
    check_eq("rr_after_reset", 32'(glog[base]), 1);

    // Requesters 0 and 2 contending
    base = glog.size();
    set_req(0, 8'h01, 8'h02);
    set_req(2, 8'h40, 8'h04);
    wait_grants(base + 4);
    bus.req_valid = '0;
    drain();
    for (int k = 0; k < 4; k++) check_eq("alt_order", 32'(glog[base+k]), 32'(alt_exp[k]));

    check_eq("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
